// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encodings and a width helper.
package divider_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Bits needed to hold values 0..v-1; never returns less than 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < v) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/subtractor.sv
// Combinational WIDTH-bit unsigned subtractor with borrow out.
module subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_minuend,
   input  logic [WIDTH-1:0] i_subtrahend,
   output logic [WIDTH-1:0] o_difference,
   output logic             o_borrow
);

   // Zero-extend both operands so the extra top bit of the result is the borrow.
   assign {o_borrow, o_difference} = {1'b0, i_minuend} - {1'b0, i_subtrahend};

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned N-bit restoring divider, one quotient bit per clock.
// Optional macro RESTORING_DIVIDER_EARLY_EXIT_EN skips iteration when dividend < divisor.
module restoring_divider
   import divider_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic         i_start,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_valid,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_div_zero
);

   localparam int unsigned CW = clog2(N);
   localparam int unsigned SW = N + 1;

   state_t         state;
   state_t         state_n;
   logic [N-1:0]   dvd;
   logic [N-1:0]   dvd_n;
   logic [N-1:0]   dvs;
   logic [N-1:0]   dvs_n;
   logic [N-1:0]   rem;
   logic [N-1:0]   rem_n;
   logic [N-1:0]   quo;
   logic [N-1:0]   quo_n;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_n;
   logic           busy_n;
   logic           valid_n;
   logic [N-1:0]   quotient_n;
   logic [N-1:0]   remainder_n;
   logic           div_zero_n;

   logic [SW-1:0]  sub_minuend;
   logic [SW-1:0]  sub_subtrahend;
   logic [SW-1:0]  sub_difference;
   logic           sub_borrow;
   logic           take_c;
   logic [N-1:0]   rem_step_c;
   logic [N-1:0]   quo_step_c;
   logic           early_c;
   logic           zero_c;

   subtractor #(
      .WIDTH (SW)
   ) u_subtractor (
      .i_minuend    (sub_minuend),
      .i_subtrahend (sub_subtrahend),
      .o_difference (sub_difference),
      .o_borrow     (sub_borrow)
   );

   assign sub_minuend    = {rem, dvd[N-1]};
   assign sub_subtrahend = {1'b0, dvs};

   // The partial remainder stays below the divisor, so the top difference bit is
   // always zero when there is no borrow; folding it in keeps every bit consumed.
   assign take_c     = ~sub_borrow & ~sub_difference[SW-1];
   assign rem_step_c = take_c ? sub_difference[N-1:0] : {rem[N-2:0], dvd[N-1]};
   assign quo_step_c = {quo[N-2:0], take_c};

   assign zero_c = (i_divisor == '0);

`ifdef RESTORING_DIVIDER_EARLY_EXIT_EN
   assign early_c = (i_dividend < i_divisor);
`else
   assign early_c = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         o_busy      <= 1'b0;
         o_valid     <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
         o_div_zero  <= 1'b0;
      end else begin
         state       <= state_n;
         dvd         <= dvd_n;
         dvs         <= dvs_n;
         rem         <= rem_n;
         quo         <= quo_n;
         cnt         <= cnt_n;
         o_busy      <= busy_n;
         o_valid     <= valid_n;
         o_quotient  <= quotient_n;
         o_remainder <= remainder_n;
         o_div_zero  <= div_zero_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_n = (zero_c || early_c) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      dvd_n       = dvd;
      dvs_n       = dvs;
      rem_n       = rem;
      quo_n       = quo;
      cnt_n       = cnt;
      quotient_n  = o_quotient;
      remainder_n = o_remainder;
      div_zero_n  = o_div_zero;
      busy_n      = (state_n != IDLE);
      valid_n     = (state_n == DONE);
      case (state)
         IDLE: begin
            if (i_start) begin
               dvd_n = i_dividend;
               dvs_n = i_divisor;
               rem_n = '0;
               quo_n = '0;
               cnt_n = CW'(N - 1);
               if (zero_c) begin
                  quotient_n  = '1;
                  remainder_n = i_dividend;
                  div_zero_n  = 1'b1;
               end else if (early_c) begin
                  quotient_n  = '0;
                  remainder_n = i_dividend;
                  div_zero_n  = 1'b0;
               end
            end
         end
         RUN: begin
            rem_n = rem_step_c;
            quo_n = quo_step_c;
            dvd_n = {dvd[N-2:0], 1'b0};
            if (cnt == '0) begin
               quotient_n  = quo_step_c;
               remainder_n = rem_step_c;
               div_zero_n  = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider with N=4.
module tb_restoring_divider;

   localparam int unsigned N = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         valid;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_zero;

   int tests;
   int failed;

   restoring_divider #(.N(N)) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_start     (start),
      .i_dividend  (dividend),
      .i_divisor   (divisor),
      .o_busy      (busy),
      .o_valid     (valid),
      .o_quotient  (quotient),
      .o_remainder (remainder),
      .o_div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation at the next edge and check its result, latency and pulse width.
   // When inject is set, a second start (9/2) is pulsed during RUN and must be ignored.
   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int exp_q, input int exp_r, input int exp_z, input int exp_lat,
                         input bit inject);
      int lat;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = $urandom_range(15, 0);
      divisor  = $urandom_range(15, 0);
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      lat = 0;
      while (!valid && lat < 20) begin
         if (inject && lat == 1) begin
            start    = 1'b1;
            dividend = 4'd9;
            divisor  = 4'd2;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      check({tag, " valid_seen"}, 32'(valid), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
      check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
      check({tag, " div_zero"}, 32'(div_zero), 32'(exp_z));
      check({tag, " busy_in_done"}, 32'(busy), 32'd1);
      tick();
      check({tag, " valid_single"}, 32'(valid), 32'd0);
      check({tag, " busy_released"}, 32'(busy), 32'd0);
      check({tag, " quotient_hold"}, 32'(quotient), 32'(exp_q));
   endtask

   initial begin
      int early_lat;
      int seen;
      tests    = 0;
      failed   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst quotient", 32'(quotient), 32'd0);
      check("rst remainder", 32'(remainder), 32'd0);
      check("rst div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;
      tick();

      run_op("13/3", 4'd13, 4'd3, 4, 1, 0, 4, 1'b0);
      run_op("15/1", 4'd15, 4'd1, 15, 0, 0, 4, 1'b0);
      run_op("15/15", 4'd15, 4'd15, 1, 0, 0, 4, 1'b0);
      run_op("7/0", 4'd7, 4'd0, 15, 7, 1, 0, 1'b0);
      run_op("5/3 ignore", 4'd5, 4'd3, 1, 2, 0, 4, 1'b1);

      // Reset asserted for the edge that ends the third RUN cycle of 12/5.
      start    = 1'b1;
      dividend = 4'd12;
      divisor  = 4'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrun busy", 32'(busy), 32'd0);
      check("midrun valid", 32'(valid), 32'd0);
      check("midrun quotient", 32'(quotient), 32'd0);
      check("midrun remainder", 32'(remainder), 32'd0);
      check("midrun div_zero", 32'(div_zero), 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (valid || busy) seen++;
      end
      check("midrun no_valid", 32'(seen), 32'd0);
      run_op("12/5", 4'd12, 4'd5, 2, 2, 0, 4, 1'b0);

`ifdef RESTORING_DIVIDER_EARLY_EXIT_EN
      early_lat = 0;
`else
      early_lat = 4;
`endif
      run_op("2/9", 4'd2, 4'd9, 0, 2, 0, early_lat, 1'b0);
      run_op("0/1", 4'd0, 4'd1, 0, 0, 0, early_lat, 1'b0);
      run_op("14/4", 4'd14, 4'd4, 3, 2, 0, 4, 1'b0);
      run_op("0/0", 4'd0, 4'd0, 15, 0, 1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
